// File: rtl/dmem_map_pkg.sv
// Shared memory map for the dmem responder: MMIO addresses, TXSTAT layout
// and the region decode used by the top level.
package dmem_map_pkg;

  localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_OUT    = 32'hFFFF_FFF1;
  localparam logic [31:0] ADDR_TXPUSH = 32'hFFFF_FFF2;
  localparam logic [31:0] ADDR_TXSTAT = 32'hFFFF_FFF3;

  localparam int TXSTAT_OVF_BIT  = 31;
  localparam int TXSTAT_FULL_BIT = 4;
  localparam int TXSTAT_CNT_LSB  = 0;
  localparam int TXSTAT_CNT_W    = 4;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_CYCLE,
    RGN_OUT,
    RGN_TXPUSH,
    RGN_TXSTAT,
    RGN_NONE
  } rgn_e;

  // RAM takes priority; MMIO addresses sit far above any legal DEPTH.
  function automatic rgn_e decode_region(input logic [31:0] addr,
                                         input int unsigned depth);
    rgn_e rgn;
    if (addr < depth) begin
      rgn = RGN_RAM;
    end else begin
      case (addr)
        ADDR_CYCLE:  rgn = RGN_CYCLE;
        ADDR_OUT:    rgn = RGN_OUT;
        ADDR_TXPUSH: rgn = RGN_TXPUSH;
        ADDR_TXSTAT: rgn = RGN_TXSTAT;
        default:     rgn = RGN_NONE;
      endcase
    end
    return rgn;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO drained over a valid/ready stream, with a sticky overflow
// flag for pushes that arrive while full and nothing is leaving.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic [31:0]                 push_data,
  input  logic                        clear_overflow,
  output logic [31:0]                 tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   storage [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop;
  logic          accept;

  assign tx_valid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign tx_data  = storage[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign accept   = push & (~full | pop);

  always_ff @(posedge clock) begin
    if (accept) begin
      storage[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !accept) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window holding a cycle
// counter, an output register and the transmit FIFO.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] out_port,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  rgn_e           rgn;
  rgn_e           rgn_q;
  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  ram_idx;
  logic [31:0]    ram_q;
  logic [31:0]    mmio_rdata;
  logic [31:0]    mmio_q;
  logic [31:0]    cycle_count;
  logic [31:0]    tx_status;
  logic           fifo_push;
  logic           fifo_clear;
  logic           fifo_full;
  logic           fifo_overflow;
  logic [FCW-1:0] fifo_count;

  assign rgn        = decode_region(address_dmem, DEPTH);
  assign ram_idx    = address_dmem[AW-1:0];
  assign fifo_push  = wren && (rgn == RGN_TXPUSH);
  assign fifo_clear = wren && (rgn == RGN_TXSTAT);

  // RAM has no reset so a write coinciding with reset still lands.
  always_ff @(posedge clock) begin
    if (wren && (rgn == RGN_RAM)) begin
      mem[ram_idx] <= data;
    end
    ram_q <= mem[ram_idx];
  end

  always_comb begin
    tx_status = '0;
    tx_status[TXSTAT_OVF_BIT]  = fifo_overflow;
    tx_status[TXSTAT_FULL_BIT] = fifo_full;
    tx_status[TXSTAT_CNT_LSB +: TXSTAT_CNT_W] = TXSTAT_CNT_W'(fifo_count);
  end

  always_comb begin
    mmio_rdata = '0;
    case (rgn)
      RGN_CYCLE:  mmio_rdata = cycle_count;
      RGN_OUT:    mmio_rdata = out_port;
      RGN_TXSTAT: mmio_rdata = tx_status;
      default:    mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
      out_port    <= '0;
      rgn_q       <= RGN_NONE;
      mmio_q      <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (wren && (rgn == RGN_OUT)) begin
        out_port <= data;
      end
      rgn_q  <= rgn;
      mmio_q <= mmio_rdata;
    end
  end

  // Reset forces rgn_q away from RAM, which makes q_dmem read as zero.
  assign q_dmem = (rgn_q == RGN_RAM) ? ram_q : mmio_q;

  tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (fifo_push),
    .push_data      (data),
    .clear_overflow (fifo_clear),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .full           (fifo_full),
    .count          (fifo_count),
    .overflow       (fifo_overflow)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver runs a transaction-level
// memory-map model and queues expectations that a monitor checks each cycle.
module tb_dmem_responder;

  localparam int unsigned DEPTH      = 4096;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FFF0;
  localparam logic [31:0] A_OUT    = 32'hFFFF_FFF1;
  localparam logic [31:0] A_TXPUSH = 32'hFFFF_FFF2;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF_FFF3;
  localparam logic [31:0] A_UNMAP  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [31:0] out_port;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  typedef struct {
    logic [31:0] q;
    bit          q_known;
    logic [31:0] outp;
    bit          txv;
    logic [31:0] txd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ram_m [int unsigned];
  logic [31:0] fifo_m[$];
  logic [31:0] cyc_m = '0;
  logic [31:0] out_m = '0;
  bit          ovf_m = 1'b0;
  int          checks = 0;
  int          errors = 0;

  dmem_responder #(
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .out_port     (out_port),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one request for the next edge and record what the map should do.
  task automatic applyStimulus(input logic rst, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic we,
                               input logic rdy);
    exp_t e;
    bit   full_before;
    bit   pop_now;
    @(negedge clock);
    reset        = rst;
    address_dmem = addr;
    data         = wdata;
    wren         = we;
    tx_ready     = rdy;

    e.q       = 32'd0;
    e.q_known = 1'b1;
    if (addr < DEPTH) begin
      if (ram_m.exists(addr)) e.q = ram_m[addr];
      else e.q_known = 1'b0;
    end else if (addr == A_CYCLE) begin
      e.q = cyc_m;
    end else if (addr == A_OUT) begin
      e.q = out_m;
    end else if (addr == A_TXSTAT) begin
      e.q = (ovf_m ? 32'h8000_0000 : 32'd0)
          | ((fifo_m.size() == FIFO_DEPTH) ? 32'h10 : 32'd0)
          | 32'(fifo_m.size());
    end

    if (we && addr < DEPTH) ram_m[addr] = wdata;

    if (rst) begin
      e.q       = 32'd0;
      e.q_known = 1'b1;
      cyc_m     = 32'd0;
      out_m     = 32'd0;
      ovf_m     = 1'b0;
      fifo_m.delete();
    end else begin
      full_before = (fifo_m.size() == FIFO_DEPTH);
      pop_now     = (fifo_m.size() > 0) && rdy;
      if (pop_now) void'(fifo_m.pop_front());
      if (we && addr == A_TXPUSH) begin
        if (full_before && !pop_now) ovf_m = 1'b1;
        else fifo_m.push_back(wdata);
      end
      if (we && addr == A_OUT) out_m = wdata;
      if (we && addr == A_TXSTAT) ovf_m = 1'b0;
      cyc_m = cyc_m + 32'd1;
    end

    e.outp = out_m;
    e.txv  = (fifo_m.size() > 0);
    e.txd  = e.txv ? fifo_m[0] : 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, A_UNMAP, 32'd0, 1'b0, rdy);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.q_known) checkOutput("q_dmem", q_dmem, e.q);
        checkOutput("out_port", out_port, e.outp);
        checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, e.txv});
        if (e.txv) checkOutput("tx_data", tx_data, e.txd);
      end
    end
  end

  initial begin
    logic [31:0] addr;
    int          sel;

    applyStimulus(1'b1, A_UNMAP, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, A_UNMAP, 32'd0, 1'b0, 1'b0);

    // RAM write, read-back and read-first collision
    applyStimulus(1'b0, 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'h0000_0001, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Cycle counter after a fresh reset, and ignored writes
    applyStimulus(1'b1, A_UNMAP, 32'd0, 1'b0, 1'b0);
    idle(9, 1'b0);
    applyStimulus(1'b0, A_CYCLE, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, A_CYCLE, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, A_CYCLE, 32'd0, 1'b0, 1'b0);

    // OUT register and unmapped space
    applyStimulus(1'b0, A_OUT, 32'h0000_00A5, 1'b1, 1'b0);
    applyStimulus(1'b0, A_OUT, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, A_UNMAP, 32'h1234_5678, 1'b1, 1'b0);
    applyStimulus(1'b0, A_UNMAP, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, DEPTH, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, A_TXPUSH, 32'd0, 1'b0, 1'b0);

    // Fill past capacity, inspect status, drain, clear overflow
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, A_TXPUSH, 32'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, A_TXSTAT, 32'd0, 1'b0, 1'b0);
    idle(5, 1'b1);
    applyStimulus(1'b0, A_TXSTAT, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, A_TXSTAT, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus(1'b0, A_TXSTAT, 32'd0, 1'b0, 1'b0);

    // Push while full with a simultaneous pop
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, A_TXPUSH, 32'(i + 16), 1'b1, 1'b0);
    applyStimulus(1'b0, A_TXPUSH, 32'd9, 1'b1, 1'b1);
    applyStimulus(1'b0, A_TXSTAT, 32'd0, 1'b0, 1'b0);
    idle(5, 1'b1);

    // Reset in the middle of activity, RAM write during reset still lands
    applyStimulus(1'b0, A_TXPUSH, 32'hAAAA_0001, 1'b1, 1'b0);
    applyStimulus(1'b0, A_TXPUSH, 32'hAAAA_0002, 1'b1, 1'b0);
    applyStimulus(1'b0, A_OUT, 32'd7, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd6, 32'h6666_6666, 1'b1, 1'b1);
    applyStimulus(1'b0, A_TXSTAT, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd6, 32'd0, 1'b0, 1'b0);

    // Randomized traffic across every region
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2: addr = 32'($urandom_range(0, 15));
        3:       addr = DEPTH - 1;
        4:       addr = A_CYCLE;
        5:       addr = A_OUT;
        6, 7:    addr = A_TXPUSH;
        8, 9:    addr = A_TXSTAT;
        10:      addr = DEPTH;
        default: addr = $urandom() | 32'h8000_0000;
      endcase
      if (addr == A_TXSTAT && ($urandom_range(0, 3) != 0)) begin
        applyStimulus(1'b0, addr, $urandom(), 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(($urandom_range(0, 79) == 0), addr, $urandom(),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      end
    end

    idle(2, 1'b0);
    @(posedge clock);
    #2;
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
